// File: rtl/rv32i_pkg.sv
// rv32i_pkg
// Shared RV32I definitions for the instruction encoder:
//   inst_fmt_e - instruction format selector (R/I/S/B/U/J, codes 6..7 invalid)
//   OP_*       - opcode constants for the common base-ISA groups
//   NOP        - canonical ADDI x0,x0,0 emitted for an unknown format
package rv32i_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } inst_fmt_e;

  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_REG    = 7'h33;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_JAL    = 7'h6F;

  localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/rv32i_pack.sv
// rv32i_pack
// Purely combinational packer: turns decoded instruction fields into one
// RV32I instruction word and flags immediate problems.
// Ports:
//   fmt     in  3   format code (inst_fmt_e encoding)
//   opcode  in  7   opcode[6:0]
//   funct3  in  3   funct3 (unused for U/J)
//   funct7  in  7   funct7 (R only)
//   rd      in  5   destination (unused for S/B)
//   rs1     in  5   source 1 (unused for U/J)
//   rs2     in  5   source 2 (R/S/B only)
//   imm     in  32  full signed byte immediate
//   inst    out 32  packed instruction word
//   err     out 1   invalid format, or immediate out of range when enabled
// Build option: define IMM_RANGE_CHECK_EN to flag immediates that do not fit
// their format (the word is still built from the truncated bits).
module rv32i_pack
  import rv32i_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] inst,
  output logic        err
);

  logic fmt_err;
  logic imm_err;

  // Field placement for each format; unknown formats collapse to a NOP so a
  // bad loader entry can never produce an unintended instruction.
  always_comb begin
    inst    = NOP;
    fmt_err = 1'b0;
    case (fmt)
      FMT_R:   inst = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I:   inst = {imm[11:0], rs1, funct3, rd, opcode};
      FMT_S:   inst = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      FMT_B:   inst = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      FMT_U:   inst = {imm[31:12], rd, opcode};
      FMT_J:   inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: begin
        inst    = NOP;
        fmt_err = 1'b1;
      end
    endcase
  end

`ifdef IMM_RANGE_CHECK_EN
  // An immediate fits an N-bit signed field when every bit above the field's
  // sign bit equals that sign bit; B and J offsets must also be even.
  always_comb begin
    imm_err = 1'b0;
    case (fmt)
      FMT_I, FMT_S: imm_err = (imm[31:11] != {21{imm[11]}});
      FMT_B:        imm_err = (imm[31:12] != {20{imm[12]}}) || imm[0];
      FMT_J:        imm_err = (imm[31:20] != {12{imm[20]}}) || imm[0];
      FMT_U:        imm_err = (imm[11:0] != 12'd0);
      default:      imm_err = 1'b0;
    endcase
  end
`else
  assign imm_err = 1'b0;
`endif

  assign err = fmt_err | imm_err;

endmodule

// File: rtl/rv32i_inst_encoder.sv
// rv32i_inst_encoder
// Packs decoded instruction fields into RV32I words through a 2-entry output
// buffer, tagging each word with its instruction-memory byte address.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   field-set handshake (ready whenever buffer not full)
//   in_fmt .. in_imm    decoded fields, see rv32i_pack
//   out_valid/out_ready word handshake, head entry shown on out_*
//   out_inst            encoded word
//   out_addr            byte address of out_inst (ADDR_W bits, wraps)
//   out_err             format / immediate error flag for this word
// Build option: IMM_RANGE_CHECK_EN enables immediate range flagging.
module rv32i_inst_encoder
  import rv32i_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [6:0]        in_opcode,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err
);

  logic [31:0]       enc_inst;
  logic              enc_err;

  logic [1:0]        count_q, count_d;
  logic [31:0]       inst_q [2];
  logic [31:0]       inst_d [2];
  logic [ADDR_W-1:0] addr_q [2];
  logic [ADDR_W-1:0] addr_d [2];
  logic              err_q  [2];
  logic              err_d  [2];
  logic [ADDR_W-1:0] pc_q, pc_d;

  logic              push;
  logic              pop;

  rv32i_pack u_pack (
    .fmt    (in_fmt),
    .opcode (in_opcode),
    .funct3 (in_funct3),
    .funct7 (in_funct7),
    .rd     (in_rd),
    .rs1    (in_rs1),
    .rs2    (in_rs2),
    .imm    (in_imm),
    .inst   (enc_inst),
    .err    (enc_err)
  );

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Slot 0 is always the head. A pop shifts slot 1 down first, then a push
  // lands in the first free slot of the post-pop occupancy, so push+pop at
  // one entry replaces the head in the same cycle.
  always_comb begin
    logic [1:0] level;
    count_d = count_q;
    inst_d  = inst_q;
    addr_d  = addr_q;
    err_d   = err_q;
    pc_d    = pc_q;
    level   = count_q;

    if (pop) begin
      inst_d[0] = inst_q[1];
      addr_d[0] = addr_q[1];
      err_d[0]  = err_q[1];
      level     = count_q - 2'd1;
    end

    if (push) begin
      inst_d[level[0]] = enc_inst;
      addr_d[level[0]] = pc_q;
      err_d[level[0]]  = enc_err;
      level            = level + 2'd1;
      pc_d             = pc_q + ADDR_W'(4);
    end

    count_d = level;
  end

  // Buffer, occupancy and address counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= 2'd0;
      inst_q[0] <= '0;
      inst_q[1] <= '0;
      addr_q[0] <= BASE_ADDR;
      addr_q[1] <= BASE_ADDR;
      err_q[0]  <= 1'b0;
      err_q[1]  <= 1'b0;
      pc_q      <= BASE_ADDR;
    end else begin
      count_q <= count_d;
      inst_q  <= inst_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
      pc_q    <= pc_d;
    end
  end

  assign out_inst = inst_q[0];
  assign out_addr = addr_q[0];
  assign out_err  = err_q[0];

endmodule

// File: doc/rv32i_inst_encoder.md
Name: rv32i_inst_encoder

Overview:
Inverse of the immediate generator. Accepts decoded instruction fields (format, opcode, funct, registers, full 32-bit immediate) over a valid/ready handshake and packs them into a legal RV32I instruction word. Results go through a 2-entry output buffer, each tagged with an instruction-memory byte address. Used by the program loader and benches to build imem images without hand-packed bit strings.

Parameters:
ADDR_W, 32, width of the output address counter
BASE_ADDR, 32'h0000_0000, address of the first word emitted after reset (must be 4-byte aligned)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  field set valid
in_ready  out  1  encoder can accept (buffer not full)
in_fmt  in  3  format code: R/I/S/B/U/J (package enum)
in_opcode  in  7  opcode[6:0]
in_funct3  in  3  funct3 (ignored for U/J)
in_funct7  in  7  funct7 (R only)
in_rd  in  5  destination register (ignored for S/B)
in_rs1  in  5  source 1 (ignored for U/J)
in_rs2  in  5  source 2 (R/S/B only)
in_imm  in  32  signed byte immediate (U: full value, low 12 bits expected 0)
out_valid  out  1  buffered word available
out_ready  in  1  consumer accepts word
out_inst  out  32  encoded instruction
out_addr  out  ADDR_W  byte address of out_inst
out_err  out  1  immediate-range error flag for this word

Behaviour:
- Clock clk; reset rst is synchronous and active-high.
- Reset: buffer count=0, out_valid=0, out_inst=0, out_addr=BASE_ADDR, out_err=0, address counter=BASE_ADDR. Reset mid-transfer discards all buffered entries.
- Push when in_valid&&in_ready; pop when out_valid&&out_ready. in_ready = (count<2). Combinational on count only, never on in_valid.
- Encoding is combinational on inputs and captured at push. Latency: pushed word is visible on out_* the next cycle when the buffer was empty.
- Packing per RISC-V spec. I: imm[11:0]. S: imm[11:5]/imm[4:0]. B: imm[12|10:5]/imm[4:1|11]. U: imm[31:12]. J: imm[20|10:1|11|19:12]. Ignored fields encode as 0.
- Address: each pushed entry stores the counter value; the counter then adds 4, wrapping modulo 2^ADDR_W.
- Buffer: 2-entry FIFO, head on out_*. Simultaneous push+pop at count=1 keeps count=1 and head advances. At count=2 no push occurs. Pop at count=0 is a no-op.
- out_* hold stable while out_valid&&!out_ready.
- Invalid in_fmt: the word encodes as 32'h0000_0013 (NOP), and out_err=1 regardless of macro.

Optional Feature:
IMM_RANGE_CHECK_EN
- Defined: out_err=1 for any of these cases:
  - I/S imm outside [-2048,2047]
  - B imm outside [-4096,4094] or odd
  - J imm outside [-2^20,2^20-2] or odd
  - U imm[11:0]!=0
  The word is still encoded from truncated bits.
- Undefined: no range logic; out_err reflects only invalid in_fmt.

Decomposition:
- Package rv32i_pkg holds:
  - inst_fmt_e enum (FMT_R=0, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J)
  - opcode constants (OP_IMM=7'h13, OP_BRANCH=7'h63, OP_REG=7'h33, OP_STORE=7'h23, OP_LUI=7'h37, OP_JAL=7'h6F)
  - NOP constant
- One sub-module, rv32i_pack: the combinational field-to-word packer plus range check. The top holds the FIFO and address counter.

Test Plan:
- ADDI x1,x0,-1 (FMT_I, op 0x13, rd=1, imm=-1) -> out_inst=0xFFF00093, out_addr=0, err=0, one cycle after push.
- ADDI x2,x0,+5 then ADD x3,x1,x2 (funct7=0) back-to-back, out_ready=1 -> 0x00500113 @0, 0x002081B3 @4, no bubbles.
- BEQ x0,x0,+8 -> 0x00000463; BEQ x0,x0,-4 -> 0xFE000EE3; B imm=3 -> err=1 (macro on) / err=0 (macro off).
- out_ready=0, three pushes attempted -> in_ready low after 2nd push; release -> words @0,4 in order, then third @8.
- ADDR_W=4, 5 pushes from BASE 0 -> addresses 0,4,8,12,0 (wrap).
- rst asserted with 2 entries buffered -> next cycle out_valid=0, in_ready=1, next push tagged BASE_ADDR.
